// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Packed result word shared with the multiplier: HI in the upper half, LO in the lower.
  typedef struct packed {
    logic [DIV_WIDTH-1:0] hi;
    logic [DIV_WIDTH-1:0] lo;
  } div_result_t;

endpackage

// File: rtl/divider_seq_div_step.sv
// One radix-2 restoring step: shift one dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction one bit wider than the operands; its MSB is the borrow.
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Out = {remainder, quotient}; truncating division, remainder takes the
// sign of the dividend. Divide-by-zero gives quotient all ones, remainder A.
// Optional macro DIVIDER_ZERO_FAST_EN: a zero divisor skips straight to DONE.
module divider_seq
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic               DivZero,
  output logic [2*WIDTH-1:0] Out
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;     // partial remainder
  logic [WIDTH-1:0] dvd;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;     // divisor magnitude
  logic             q_neg;
  logic             r_neg;
  logic             b_zero;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (dvs),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      b_zero  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Out     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            dvd     <= (Signed && A[WIDTH-1]) ? -A : A;
            dvs     <= (Signed && B[WIDTH-1]) ? -B : B;
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            q_neg   <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]) && (B != '0);
            r_neg   <= Signed && A[WIDTH-1];
            b_zero  <= (B == '0);
            DivZero <= 1'b0;
            Busy    <= 1'b1;
`ifdef DIVIDER_ZERO_FAST_EN
            if (B == '0) begin
              Out   <= {A, {WIDTH{1'b1}}};
              state <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state   <= CALC;
`endif
          end
        end
        CALC: begin
          rem <= step_rem;
          dvd <= {dvd[WIDTH-2:0], step_q};
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          Out   <= {(r_neg ? -rem : rem), (q_neg ? -dvd : dvd)};
          state <= DONE;
        end
        DONE: begin
          Done    <= 1'b1;
          Busy    <= 1'b0;
          DivZero <= b_zero;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
